// File: rtl/v_issue_seq.sv
// Single-issue vector sequencer: accepts one instruction, starts one functional unit,
// waits for its done (with a timeout), then emits writeback/retire strobes.
module v_issue_seq #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  input  logic [2:0]       unit_sel,
  output logic             instr_ready,
  output logic [31:0]      instr_q,
  output logic [5:0]       start,
  input  logic [5:0]       done_vec,
  output logic             wb_en,
  output logic             vcfg_wr_en,
  output logic             retire,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  localparam logic [2:0] SEL_ILLEGAL = 3'd0;
  localparam logic [2:0] SEL_STORE   = 3'd6;
  localparam logic [2:0] SEL_CONFIG  = 3'd7;

  localparam int unsigned    TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  // Unit selects 1..6 map to start/done bit sel-1; illegal and CONFIG map to no unit.
  function automatic logic [5:0] unit_onehot(input logic [2:0] sel);
    logic [5:0] oh;
    oh = 6'b0;
    if (sel != SEL_ILLEGAL && sel != SEL_CONFIG) oh = 6'b1 << (sel - 3'd1);
    return oh;
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        instr_d;
  logic [2:0]         unit_q, unit_d;
  logic [5:0]         start_q, start_d;
  logic               wb_en_q, wb_en_d;
  logic               vcfg_q, vcfg_d;
  logic               retire_q, retire_d;
  logic               err_ill_q, err_ill_d;
  logic               err_to_q, err_to_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        instr_r;
  logic               unit_done;

  assign unit_done = |(unit_onehot(unit_q) & done_vec);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    instr_d   = instr_r;
    unit_d    = unit_q;
    start_d   = 6'b0;
    wb_en_d   = 1'b0;
    vcfg_d    = 1'b0;
    retire_d  = 1'b0;
    err_ill_d = 1'b0;
    err_to_d  = 1'b0;
    timer_d   = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr_in;
          unit_d  = unit_sel;
          if (unit_sel == SEL_ILLEGAL) begin
            err_ill_d = 1'b1;
            retire_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            start_d = unit_onehot(unit_sel);
          end
        end
      end
      S_ISSUE: begin
        if (unit_q == SEL_CONFIG || unit_done) begin
          state_d = S_WB;
        end else begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        // A done arriving on the final timer cycle still completes normally.
        if (unit_done) begin
          state_d = S_WB;
        end else if (timer_q == TMR_LAST) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
          retire_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are set on the edge that enters WB.
    if (state_d == S_WB) begin
      retire_d = 1'b1;
      vcfg_d   = (unit_q == SEL_CONFIG);
      wb_en_d  = (unit_q != SEL_CONFIG) && (unit_q != SEL_STORE);
    end

    cnt_d = cnt_q + CNT_W'(retire_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      instr_r   <= 32'b0;
      unit_q    <= 3'b0;
      start_q   <= 6'b0;
      wb_en_q   <= 1'b0;
      vcfg_q    <= 1'b0;
      retire_q  <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
      timer_q   <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q   <= state_d;
      instr_r   <= instr_d;
      unit_q    <= unit_d;
      start_q   <= start_d;
      wb_en_q   <= wb_en_d;
      vcfg_q    <= vcfg_d;
      retire_q  <= retire_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign instr_q     = instr_r;
  assign start       = start_q;
  assign wb_en       = wb_en_q;
  assign vcfg_wr_en  = vcfg_q;
  assign retire      = retire_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;
  assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_v_issue_seq.sv
// Directed bench for v_issue_seq: unit issue latencies, timeout, illegal, reset and counter wrap.
module tb_v_issue_seq;

  localparam int unsigned TO_CYC = 4;

  logic        clk;
  logic        nrst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic [2:0]  unit_sel;
  logic [5:0]  done_vec;

  logic        instr_ready, wb_en, vcfg_wr_en, retire, busy, err_illegal, err_timeout;
  logic [31:0] instr_q;
  logic [5:0]  start;
  logic [15:0] retire_cnt;

  logic        instr_ready_n, wb_en_n, vcfg_wr_en_n, retire_n, busy_n, err_illegal_n, err_timeout_n;
  logic [31:0] instr_q_n;
  logic [5:0]  start_n;
  logic [3:0]  retire_cnt_n;

  int n_checks = 0;
  int n_errors = 0;

  v_issue_seq #(.TIMEOUT_CYC(TO_CYC), .CNT_W(16)) u_dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr_in(instr_in),
    .unit_sel(unit_sel), .instr_ready(instr_ready), .instr_q(instr_q), .start(start),
    .done_vec(done_vec), .wb_en(wb_en), .vcfg_wr_en(vcfg_wr_en), .retire(retire),
    .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .retire_cnt(retire_cnt)
  );

  // Narrow-counter copy sharing the stimulus, used to observe counter wrap quickly.
  v_issue_seq #(.TIMEOUT_CYC(TO_CYC), .CNT_W(4)) u_dut_n (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr_in(instr_in),
    .unit_sel(unit_sel), .instr_ready(instr_ready_n), .instr_q(instr_q_n), .start(start_n),
    .done_vec(done_vec), .wb_en(wb_en_n), .vcfg_wr_en(vcfg_wr_en_n), .retire(retire_n),
    .busy(busy_n), .err_illegal(err_illegal_n), .err_timeout(err_timeout_n),
    .retire_cnt(retire_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in an IDLE cycle; returns in cycle 1 (ISSUE).
  task automatic accept(input logic [2:0] sel, input logic [31:0] word);
    check("ready_before_accept", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_in    = word;
    unit_sel    = sel;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    nrst        = 1'b0;
    instr_valid = 1'b0;
    instr_in    = 32'h0;
    unit_sel    = 3'd0;
    done_vec    = 6'b0;
    #12;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_instr_q", instr_q, 32'd0);
    check("rst_strobes", {wb_en, vcfg_wr_en, retire, err_illegal, err_timeout}, 32'd0);
    check("rst_cnt", 32'(retire_cnt), 32'd0);
    check("rst_cnt_n", 32'(retire_cnt_n), 32'd0);
    #10 nrst = 1'b1;
    tick();

    // ALU, done in cycle 3
    accept(3'd1, 32'hA0A0_0001);
    check("alu_start_c1", 32'(start), 32'h01);
    check("alu_busy_c1", 32'(busy), 32'd1);
    check("alu_ready_c1", 32'(instr_ready), 32'd0);
    check("alu_instr_q", instr_q, 32'hA0A0_0001);
    tick();
    check("alu_start_c2", 32'(start), 32'd0);
    tick();
    done_vec = 6'b000001;
    tick();
    done_vec = 6'b0;
    check("alu_wb_c4", 32'(wb_en), 32'd1);
    check("alu_retire_c4", 32'(retire), 32'd1);
    check("alu_cnt", 32'(retire_cnt), 32'd1);
    check("alu_cnt_n", 32'(retire_cnt_n), 32'd1);
    tick();
    check("alu_ready_c5", 32'(instr_ready), 32'd1);
    check("alu_wb_off_c5", 32'(wb_en), 32'd0);

    // STORE, done in cycle 2, never writes back
    accept(3'd6, 32'h5700_0006);
    check("st_start_c1", 32'(start), 32'h20);
    tick();
    check("st_wb_c2", 32'(wb_en), 32'd0);
    done_vec = 6'b100000;
    tick();
    done_vec = 6'b0;
    check("st_retire_c3", 32'(retire), 32'd1);
    check("st_wb_c3", 32'(wb_en), 32'd0);
    check("st_cnt", 32'(retire_cnt), 32'd2);
    tick();
    check("st_ready_c4", 32'(instr_ready), 32'd1);

    // CONFIG, with an illegal instruction held by the producer while busy
    accept(3'd7, 32'hC0F1_0007);
    check("cfg_start_c1", 32'(start), 32'd0);
    instr_valid = 1'b1;
    instr_in    = 32'hDEAD_0000;
    unit_sel    = 3'd0;
    tick();
    check("cfg_vcfg_c2", 32'(vcfg_wr_en), 32'd1);
    check("cfg_retire_c2", 32'(retire), 32'd1);
    check("cfg_wb_c2", 32'(wb_en), 32'd0);
    check("cfg_instr_hold", instr_q, 32'hC0F1_0007);
    check("cfg_cnt", 32'(retire_cnt), 32'd3);
    tick();
    check("cfg_ready_c3", 32'(instr_ready), 32'd1);
    check("cfg_vcfg_off_c3", 32'(vcfg_wr_en), 32'd0);
    tick();
    instr_valid = 1'b0;
    check("ill_err", 32'(err_illegal), 32'd1);
    check("ill_retire", 32'(retire), 32'd1);
    check("ill_start", 32'(start), 32'd0);
    check("ill_ready", 32'(instr_ready), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_instr_q", instr_q, 32'hDEAD_0000);
    check("ill_cnt", 32'(retire_cnt), 32'd4);
    tick();
    check("ill_err_off", 32'(err_illegal), 32'd0);

    // MUL with done in the ISSUE cycle
    accept(3'd2, 32'h0E00_0002);
    check("mul_start_c1", 32'(start), 32'h02);
    done_vec = 6'b000010;
    tick();
    done_vec = 6'b0;
    check("mul_wb_c2", 32'(wb_en), 32'd1);
    check("mul_retire_c2", 32'(retire), 32'd1);
    check("mul_cnt", 32'(retire_cnt), 32'd5);
    tick();
    check("mul_ready_c3", 32'(instr_ready), 32'd1);

    // RED timeout; a foreign done bit during WAIT must be ignored
    accept(3'd4, 32'hF000_0004);
    check("red_start_c1", 32'(start), 32'h08);
    done_vec = 6'b000010;
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("red_quiet_c%0d", c), {30'd0, wb_en, retire}, 32'd0);
      check($sformatf("red_busy_c%0d", c), 32'(busy), 32'd1);
    end
    tick();
    done_vec = 6'b0;
    check("red_timeout_c6", 32'(err_timeout), 32'd1);
    check("red_retire_c6", 32'(retire), 32'd1);
    check("red_wb_c6", 32'(wb_en), 32'd0);
    check("red_ready_c6", 32'(instr_ready), 32'd1);
    check("red_cnt", 32'(retire_cnt), 32'd6);
    tick();
    check("red_timeout_off", 32'(err_timeout), 32'd0);

    // RED with done on the final timer cycle: done wins
    accept(3'd4, 32'h6000_0004);
    tick();
    tick();
    tick();
    tick();
    done_vec = 6'b001000;
    tick();
    done_vec = 6'b0;
    check("redlast_wb_c6", 32'(wb_en), 32'd1);
    check("redlast_timeout_c6", 32'(err_timeout), 32'd0);
    check("redlast_cnt", 32'(retire_cnt), 32'd7);
    tick();

    // Reset during MUL WAIT
    accept(3'd2, 32'h1111_0002);
    tick();
    check("mrst_busy_pre", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(instr_ready), 32'd1);
    check("mrst_cnt", 32'(retire_cnt), 32'd0);
    check("mrst_cnt_n", 32'(retire_cnt_n), 32'd0);
    check("mrst_instr_q", instr_q, 32'd0);
    #2 nrst = 1'b1;
    tick();
    check("mrst_no_retire", {30'd0, wb_en, retire}, 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);

    // Back-to-back illegal retires: 20 wraps the 4-bit counter to 4
    instr_valid = 1'b1;
    unit_sel    = 3'd0;
    instr_in    = 32'h0BAD_0000;
    for (int i = 0; i < 20; i++) tick();
    instr_valid = 1'b0;
    check("wrap_retire", 32'(retire), 32'd1);
    check("wrap_cnt16", 32'(retire_cnt), 32'd20);
    check("wrap_cnt4", 32'(retire_cnt_n), 32'd4);
    tick();
    check("wrap_retire_off", 32'(retire), 32'd0);
    check("wrap_cnt16_hold", 32'(retire_cnt), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
